i2c_key_controller: RTL

Parametrised successor to the I2C slave controller FSM. It sequences address ACK/NACK, multi-byte key reception and FIFO-fed transmit for the I2C slave datapath, between the start/stop detector, the shift registers and the TX FIFO. New versus the previous generation:
- the key length is counted internally (KEY_BYTES), so there is no external key_received;
- repeated START is handled;
- a transmit underrun terminates the transfer cleanly;
- a stall watchdog (timeout_err) returns the FSM to IDLE.

---
 rtl/i2c_ctrl_pkg.sv | 25 ++
 rtl/i2c_stall_timer.sv | 29 ++
 rtl/i2c_key_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2c_ctrl_pkg.sv
// Shared types for the I2C key controller: FSM state encoding and SDA drive modes.
package i2c_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    WAIT_FOR_BYTE = 4'd1,
    RX_BYTE       = 4'd2,
    PREP_ACK      = 4'd3,
    ACK_TX        = 4'd4,
    ACK_RX        = 4'd5,
    LOAD_BYTE     = 4'd6,
    SEND_BYTE     = 4'd7,
    RX_REG_LOAD   = 4'd8,
    MAKE_BUS_IDLE = 4'd9,
    MASTER_ACK    = 4'd10,
    RX_WAIT       = 4'd11,
    RX_ACK_PREP   = 4'd12,
    RX_KEY_SIGNAL = 4'd13
  } state_t;

  localparam logic [1:0] SDA_RELEASE = 2'b00;
  localparam logic [1:0] SDA_ACK     = 2'b01;
  localparam logic [1:0] SDA_TX      = 2'b11;

endpackage

// File: rtl/i2c_stall_timer.sv
// Stall watchdog: counts enabled cycles since the last clear and flags expiry
// on the LIMIT-th such cycle. LIMIT = 0 disables it.
module i2c_stall_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] count;

  // Holds at LAST so a blocked expiry cannot wrap back to an early count.
  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (LIMIT > 0) && enable && (count == LAST);

endmodule

// File: rtl/i2c_key_controller.sv
// I2C slave sequencing FSM: address ACK/NACK, fixed-length key reception and
// FIFO-fed transmit, with repeated START handling and a stall watchdog.
module i2c_key_controller
  import i2c_ctrl_pkg::*;
#(
  parameter int KEY_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ALLOW_TX       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_found,
  input  logic                             stop_found,
  input  logic                             byte_received,
  input  logic                             ack_prep,
  input  logic                             check_ack,
  input  logic                             ack_done,
  input  logic                             rw_mode,
  input  logic                             address_match,
  input  logic                             sda_in,
  input  logic                             fifo_empty,
  output logic                             rx_enable,
  output logic                             tx_enable,
  output logic                             read_enable,
  output logic                             load_data,
  output logic                             reg_enable,
  output logic                             start_byte_received,
  output logic [1:0]                       sda_mode,
  output logic                             key_loaded,
  output logic [$clog2(KEY_BYTES+1)-1:0]   byte_count,
  output logic                             timeout_err
);

  localparam int CW = $clog2(KEY_BYTES + 1);
  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BYTES);

  state_t state, state_next;
  logic   wd_enable, wd_clear, wd_expire, wd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus conditions override everything; the watchdog only acts when neither is present.
  always_comb begin
    state_next          = state;
    wd_fire             = 1'b0;
    rx_enable           = 1'b0;
    tx_enable           = 1'b0;
    read_enable         = 1'b0;
    load_data           = 1'b0;
    reg_enable          = 1'b0;
    start_byte_received = 1'b0;
    sda_mode            = SDA_RELEASE;

    if (stop_found && (state != IDLE)) begin
      state_next = IDLE;
    end else if (start_found) begin
      state_next = WAIT_FOR_BYTE;
    end else if (wd_expire) begin
      state_next = IDLE;
      wd_fire    = 1'b1;
    end else begin
      case (state)
        IDLE:          state_next = IDLE;
        WAIT_FOR_BYTE: if (byte_received) state_next = PREP_ACK;
        PREP_ACK: begin
          if (ack_prep) begin
            if (rw_mode && address_match && !fifo_empty && (ALLOW_TX != 0)) begin
              state_next = ACK_TX;
            end else if (!rw_mode && address_match && !key_loaded) begin
              state_next = ACK_RX;
            end else begin
              state_next = IDLE;
            end
          end
        end
        ACK_TX:        if (ack_done) state_next = LOAD_BYTE;
        LOAD_BYTE:     state_next = SEND_BYTE;
        SEND_BYTE:     if (ack_prep) state_next = MAKE_BUS_IDLE;
        MAKE_BUS_IDLE: if (check_ack) state_next = MASTER_ACK;
        MASTER_ACK:    state_next = sda_in ? IDLE : RX_WAIT;
        RX_WAIT:       if (ack_done) state_next = fifo_empty ? IDLE : LOAD_BYTE;
        ACK_RX:        if (ack_done) state_next = (byte_count == KEY_LAST) ? RX_REG_LOAD : RX_BYTE;
        RX_BYTE:       if (byte_received) state_next = RX_ACK_PREP;
        RX_ACK_PREP:   if (ack_prep) state_next = ACK_RX;
        RX_REG_LOAD:   state_next = RX_KEY_SIGNAL;
        RX_KEY_SIGNAL: state_next = IDLE;
        default:       state_next = IDLE;
      endcase
    end

    case (state)
      WAIT_FOR_BYTE, RX_BYTE: rx_enable = 1'b1;
      PREP_ACK:               start_byte_received = 1'b1;
      ACK_TX, ACK_RX:         sda_mode = SDA_ACK;
      LOAD_BYTE: begin
        read_enable = 1'b1;
        load_data   = 1'b1;
      end
      SEND_BYTE: begin
        tx_enable = 1'b1;
        sda_mode  = SDA_TX;
      end
      RX_REG_LOAD:            reg_enable = 1'b1;
      default:                ;
    endcase
  end

  // Key commit states advance on their own, so they are excluded from the watchdog.
  assign wd_enable = (state != IDLE) && (state != RX_REG_LOAD) && (state != RX_KEY_SIGNAL);
  assign wd_clear  = (state_next != state) || start_found;

  i2c_stall_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (wd_enable),
    .clear  (wd_clear),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count  <= '0;
      key_loaded  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire;
      if ((state_next == WAIT_FOR_BYTE) && ((state != WAIT_FOR_BYTE) || start_found)) begin
        byte_count <= '0;
      end else if ((state == RX_BYTE) && (state_next == RX_ACK_PREP) && (byte_count != KEY_LAST)) begin
        byte_count <= byte_count + CW'(1);
      end
      if (state_next == RX_KEY_SIGNAL) begin
        key_loaded <= 1'b1;
      end
    end
  end

endmodule
